// File: rtl/ram_arbiter_if.sv
// Client and RAM-side signal bundle for ram_arbiter.
// slave is the arbiter's view, master is the view of the logic around it
// (both clients plus the RAM wrapper).
interface ram_arbiter_if #(
  parameter int DATA_WIDE = 32,
  parameter int ADDR_WIDE = 9
);
  // client 0
  logic                 req0_valid;
  logic                 req0_we;
  logic [ADDR_WIDE-1:0] req0_addr;
  logic [DATA_WIDE-1:0] req0_wdata;
  logic                 req0_ready;
  logic                 rsp0_valid;
  logic [DATA_WIDE-1:0] rsp0_rdata;
  logic                 rsp0_err;
  // client 1
  logic                 req1_valid;
  logic                 req1_we;
  logic [ADDR_WIDE-1:0] req1_addr;
  logic [DATA_WIDE-1:0] req1_wdata;
  logic                 req1_ready;
  logic                 rsp1_valid;
  logic [DATA_WIDE-1:0] rsp1_rdata;
  logic                 rsp1_err;
  // RAM side
  logic                 ram_wr_en;
  logic                 ram_re_en;
  logic [ADDR_WIDE-1:0] ram_addr;
  logic [DATA_WIDE-1:0] ram_wdata;
  logic [DATA_WIDE-1:0] ram_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    output ram_wr_en, ram_re_en, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
    input  ram_wr_en, ram_re_en, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-client round-robin arbiter and sequencer for a single-port synchronous
// RAM. One transaction is in flight at a time: accept in IDLE, one RAM
// command cycle, RD_LAT wait cycles for reads, then a one-cycle response.
// Out-of-range addresses skip the RAM and answer with err=1 immediately.
module ram_arbiter #(
  parameter int DATA_WIDE = 32,
  parameter int DEEP      = 512,
  parameter int ADDR_WIDE = $clog2(DEEP),
  parameter int RD_LAT    = 1
) (
  input logic          clk,
  input logic          rst_n,
  ram_arbiter_if.slave bus
);

  localparam int                   CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(RD_LAT - 1);
  // one extra bit so DEEP itself is representable when it is a power of two
  localparam logic [ADDR_WIDE:0]   DEEP_EXT = (ADDR_WIDE + 1)'(DEEP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t               state_r;
  state_t               next_state_s;
  logic                 last_grant_r;
  logic                 cap_we_r;
  logic                 cap_id_r;
  logic                 cap_err_r;
  logic [CNT_W-1:0]     wait_cnt_r;

  logic                 sel_valid_s;
  logic                 sel_id_s;
  logic                 sel_we_s;
  logic [ADDR_WIDE-1:0] sel_addr_s;
  logic [DATA_WIDE-1:0] sel_wdata_s;
  logic                 sel_err_s;
  logic                 req0_ready_s;
  logic                 req1_ready_s;
  logic                 accept_s;

  logic                 resp_id_s;
  logic                 resp_err_s;
  logic [DATA_WIDE-1:0] resp_data_s;

  logic                 ram_wr_en_r;
  logic                 ram_re_en_r;
  logic [ADDR_WIDE-1:0] ram_addr_r;
  logic [DATA_WIDE-1:0] ram_wdata_r;
  logic                 rsp0_valid_r;
  logic [DATA_WIDE-1:0] rsp0_rdata_r;
  logic                 rsp0_err_r;
  logic                 rsp1_valid_r;
  logic [DATA_WIDE-1:0] rsp1_rdata_r;
  logic                 rsp1_err_r;

  // Round-robin pick: a lone requester wins, on contention the client that
  // was not granted last wins.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_id_s    = 1'b0;
    case ({bus.req1_valid, bus.req0_valid})
      2'b01: begin
        sel_valid_s = 1'b1;
        sel_id_s    = 1'b0;
      end
      2'b10: begin
        sel_valid_s = 1'b1;
        sel_id_s    = 1'b1;
      end
      2'b11: begin
        sel_valid_s = 1'b1;
        sel_id_s    = ~last_grant_r;
      end
      default: begin
        sel_valid_s = 1'b0;
        sel_id_s    = 1'b0;
      end
    endcase
  end

  // Request fields of the selected client, range check and ready strobes.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = {ADDR_WIDE{1'b0}};
    sel_wdata_s = {DATA_WIDE{1'b0}};
    if (sel_id_s) begin
      sel_we_s    = bus.req1_we;
      sel_addr_s  = bus.req1_addr;
      sel_wdata_s = bus.req1_wdata;
    end else begin
      sel_we_s    = bus.req0_we;
      sel_addr_s  = bus.req0_addr;
      sel_wdata_s = bus.req0_wdata;
    end
    sel_err_s = ({1'b0, sel_addr_s} >= DEEP_EXT);
    // ready is gated by rst_n so nothing looks accepted while held in reset
    req0_ready_s = rst_n && (state_r == ST_IDLE) && sel_valid_s && !sel_id_s;
    req1_ready_s = rst_n && (state_r == ST_IDLE) && sel_valid_s &&  sel_id_s;
    accept_s     = req0_ready_s || req1_ready_s;
  end

  // Next-state logic of the transaction sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = sel_err_s ? ST_RESP : ST_CMD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CMD: begin
        next_state_s = cap_we_r ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_r == {CNT_W{1'b0}}) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Source of the response about to be issued: errors come straight from
  // the accept cycle, reads take the RAM word at the end of the last WAIT.
  always_comb begin
    resp_id_s   = cap_id_r;
    resp_err_s  = cap_err_r;
    resp_data_s = {DATA_WIDE{1'b0}};
    if (state_r == ST_IDLE) begin
      resp_id_s  = sel_id_s;
      resp_err_s = sel_err_s;
    end else begin
      resp_id_s  = cap_id_r;
      resp_err_s = cap_err_r;
    end
    if (state_r == ST_WAIT) begin
      resp_data_s = bus.ram_rdata;
    end else begin
      resp_data_s = {DATA_WIDE{1'b0}};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Capture the accepted request and remember who was granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 1'b1;
      cap_we_r     <= 1'b0;
      cap_id_r     <= 1'b0;
      cap_err_r    <= 1'b0;
    end else if (accept_s) begin
      last_grant_r <= sel_id_s;
      cap_we_r     <= sel_we_s;
      cap_id_r     <= sel_id_s;
      cap_err_r    <= sel_err_s;
    end
  end

  // RAM command: loaded on accept so it is presented only in the CMD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_wr_en_r <= 1'b0;
      ram_re_en_r <= 1'b0;
      ram_addr_r  <= {ADDR_WIDE{1'b0}};
      ram_wdata_r <= {DATA_WIDE{1'b0}};
    end else if (accept_s && !sel_err_s) begin
      ram_wr_en_r <= sel_we_s;
      ram_re_en_r <= !sel_we_s;
      ram_addr_r  <= sel_addr_s;
      ram_wdata_r <= sel_wdata_s;
    end else begin
      ram_wr_en_r <= 1'b0;
      ram_re_en_r <= 1'b0;
      ram_addr_r  <= {ADDR_WIDE{1'b0}};
      ram_wdata_r <= {DATA_WIDE{1'b0}};
    end
  end

  // Read latency counter: loaded in CMD, counts down through WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_CMD) begin
      wait_cnt_r <= CNT_LOAD;
    end else if ((state_r == ST_WAIT) && (wait_cnt_r != {CNT_W{1'b0}})) begin
      wait_cnt_r <= wait_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Response registers: one-cycle valid pulse, data/err held until the next
  // response to the same client.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_r <= 1'b0;
      rsp0_rdata_r <= {DATA_WIDE{1'b0}};
      rsp0_err_r   <= 1'b0;
      rsp1_valid_r <= 1'b0;
      rsp1_rdata_r <= {DATA_WIDE{1'b0}};
      rsp1_err_r   <= 1'b0;
    end else begin
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      if (next_state_s == ST_RESP) begin
        if (resp_id_s) begin
          rsp1_valid_r <= 1'b1;
          rsp1_rdata_r <= resp_data_s;
          rsp1_err_r   <= resp_err_s;
        end else begin
          rsp0_valid_r <= 1'b1;
          rsp0_rdata_r <= resp_data_s;
          rsp0_err_r   <= resp_err_s;
        end
      end
    end
  end

  assign bus.req0_ready = req0_ready_s;
  assign bus.req1_ready = req1_ready_s;
  assign bus.rsp0_valid = rsp0_valid_r;
  assign bus.rsp0_rdata = rsp0_rdata_r;
  assign bus.rsp0_err   = rsp0_err_r;
  assign bus.rsp1_valid = rsp1_valid_r;
  assign bus.rsp1_rdata = rsp1_rdata_r;
  assign bus.rsp1_err   = rsp1_err_r;
  assign bus.ram_wr_en  = ram_wr_en_r;
  assign bus.ram_re_en  = ram_re_en_r;
  assign bus.ram_addr   = ram_addr_r;
  assign bus.ram_wdata  = ram_wdata_r;

endmodule
